// File: rtl/hub75_bcm_row_driver.sv
// HUB-75 row driver: shifts one row pair per bit plane from a line buffer, then
// blanks, latches and lights the row for a time weighted by the plane's significance.
module hub75_bcm_row_driver #(
   parameter int WIDTH        = 64,
   parameter int ADDR_BITS    = 6,
   parameter int DEPTH        = 8,
   parameter int ROW_BITS     = 5,
   parameter int CLK_DIV      = 2,
   parameter int BLANK_CYCLES = 1,
   parameter int LAT_CYCLES   = 1,
   parameter int BASE_TICKS   = 4,
   parameter int BR_BITS      = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ROW_BITS-1:0]   row,
   input  logic                  bank,
   input  logic [BR_BITS-1:0]    brightness,
   output logic                  is_idle,
   output logic                  done,
   output logic [ADDR_BITS:0]    read_address,
   input  logic [6*DEPTH-1:0]    read_data,
   output logic                  hub_r1,
   output logic                  hub_g1,
   output logic                  hub_b1,
   output logic                  hub_r2,
   output logic                  hub_g2,
   output logic                  hub_b2,
   output logic [ROW_BITS-1:0]   hub_abcde,
   output logic                  hub_clk,
   output logic                  hub_lat,
   output logic                  hub_oe
);

   localparam int PHASE_W = $clog2(CLK_DIV);
   localparam int PLANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TICK_W  = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
   localparam int SHOW_W  = DEPTH + $clog2(BASE_TICKS);
   localparam int GAP_W   = $clog2(((BLANK_CYCLES > LAT_CYCLES) ? BLANK_CYCLES : LAT_CYCLES) + 1);
   localparam int CNT_W   = (SHOW_W > GAP_W) ? SHOW_W : GAP_W;

   typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;

   state_t               state_q, state_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [ADDR_BITS-1:0] x_q, x_d;
   logic [PLANE_W-1:0]   plane_q, plane_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic                 bank_q, bank_d;
   logic [BR_BITS-1:0]   bright_q, bright_d;
   logic                 done_q, done_d;
   logic                 hubClk_q, hubClk_d;
   logic                 hubLat_q, hubLat_d;
   logic                 hubOe_q, hubOe_d;
   logic [ROW_BITS-1:0]  abcde_q, abcde_d;
   logic [CNT_W-1:0]     showLast;
   logic [5:0]           colour;

   assign showLast = (CNT_W'(BASE_TICKS) << plane_q) - CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      x_d      = x_q;
      plane_d  = plane_q;
      cnt_d    = cnt_q;
      tick_d   = tick_q;
      row_d    = row_q;
      bank_d   = bank_q;
      bright_d = bright_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               row_d    = row;
               bank_d   = bank;
               bright_d = brightness;
               plane_d  = '0;
               phase_d  = '0;
               x_d      = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (phase_q == PHASE_W'(CLK_DIV - 1)) begin
               phase_d = '0;
               if (x_q == ADDR_BITS'(WIDTH - 1)) begin
                  x_d     = '0;
                  cnt_d   = '0;
                  state_d = BLANK;
               end else begin
                  x_d = x_q + ADDR_BITS'(1);
               end
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = LATCH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LATCH: begin
            if (cnt_q == CNT_W'(LAT_CYCLES - 1)) begin
               cnt_d   = '0;
               tick_d  = '0;
               state_d = SHOW;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHOW: begin
            // tick is the position inside one BASE_TICKS unit; it drives the PWM duty
            tick_d = (tick_q == TICK_W'(BASE_TICKS - 1)) ? '0 : tick_q + TICK_W'(1);
            if (cnt_q == showLast) begin
               cnt_d = '0;
               if (plane_q == PLANE_W'(DEPTH - 1)) begin
                  plane_d = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  plane_d = plane_q + PLANE_W'(1);
                  phase_d = '0;
                  x_d     = '0;
                  state_d = SHIFT;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Panel strobes are precomputed from the next state so they leave flops cleanly
      hubClk_d = (state_d == SHIFT) && (phase_d >= PHASE_W'(CLK_DIV / 2));
      hubLat_d = (state_d == LATCH);
      hubOe_d  = !((state_d == SHOW) && (BR_BITS'(tick_d) < bright_d));
      abcde_d  = abcde_q;
      if ((state_q == BLANK) && (state_d == LATCH) && (plane_q == '0))
         abcde_d = row_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         x_q      <= '0;
         plane_q  <= '0;
         cnt_q    <= '0;
         tick_q   <= '0;
         row_q    <= '0;
         bank_q   <= 1'b0;
         bright_q <= '0;
         done_q   <= 1'b0;
         hubClk_q <= 1'b0;
         hubLat_q <= 1'b0;
         hubOe_q  <= 1'b1;
         abcde_q  <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         x_q      <= x_d;
         plane_q  <= plane_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         row_q    <= row_d;
         bank_q   <= bank_d;
         bright_q <= bright_d;
         done_q   <= done_d;
         hubClk_q <= hubClk_d;
         hubLat_q <= hubLat_d;
         hubOe_q  <= hubOe_d;
         abcde_q  <= abcde_d;
      end
   end

   // Pick bit "plane" of each colour channel; data is only meaningful while shifting
   for (genvar c = 0; c < 6; c++) begin : gColour
      logic [DEPTH-1:0] chan;
      assign chan      = read_data[c*DEPTH +: DEPTH];
      assign colour[c] = (state_q == SHIFT) && chan[plane_q];
   end

   assign {hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1} = colour;
   assign is_idle      = (state_q == IDLE);
   assign done         = done_q;
   assign read_address = {bank_q, x_q};
   assign hub_abcde    = abcde_q;
   assign hub_clk      = hubClk_q;
   assign hub_lat      = hubLat_q;
   assign hub_oe       = hubOe_q;

endmodule

// File: tb/tb_hub75_bcm_row_driver.sv
// Bench for hub75_bcm_row_driver: directed rows plus random rows, each checked
// cycle by cycle against a timeline model built from the row-time arithmetic.
module tb_hub75_bcm_row_driver;

   localparam int W   = 4;
   localparam int AB  = 2;
   localparam int D   = 2;
   localparam int RB  = 5;
   localparam int CD  = 2;
   localparam int BC  = 1;
   localparam int LC  = 1;
   localparam int BT  = 4;
   localparam int BRB = 3;
   localparam int ROW_TIME = D * (W * CD + BC + LC) + BT * ((1 << D) - 1);

   logic            clock;
   logic            reset;
   logic            start;
   logic [RB-1:0]   row;
   logic            bank;
   logic [BRB-1:0]  brightness;
   logic            is_idle;
   logic            done;
   logic [AB:0]     read_address;
   logic [6*D-1:0]  read_data;
   logic            hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
   logic [RB-1:0]   hub_abcde;
   logic            hub_clk, hub_lat, hub_oe;

   logic [6*D-1:0]  mem [1 << (AB + 1)];
   logic [RB-1:0]   lastRow;
   int              checks;
   int              errors;

   hub75_bcm_row_driver #(
      .WIDTH(W), .ADDR_BITS(AB), .DEPTH(D), .ROW_BITS(RB), .CLK_DIV(CD),
      .BLANK_CYCLES(BC), .LAT_CYCLES(LC), .BASE_TICKS(BT), .BR_BITS(BRB)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .row(row), .bank(bank),
      .brightness(brightness), .is_idle(is_idle), .done(done),
      .read_address(read_address), .read_data(read_data),
      .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
      .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
      .hub_abcde(hub_abcde), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Line buffer with one cycle of read latency
   always @(posedge clock) read_data <= mem[read_address];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] colourNow();
      return {hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1};
   endfunction

   function automatic logic [18:0] outputsNow();
      return {is_idle, done, read_address, colourNow(), hub_abcde, hub_clk, hub_lat, hub_oe};
   endfunction

   // Expected strobe levels k cycles after the start edge, walking the plane timeline
   function automatic void model(input int k, input int br, output bit eClk, output bit eLat, output bit eOe);
      int base, shEnd, showStart, showLen;
      eClk = 1'b0;
      eLat = 1'b0;
      eOe  = 1'b1;
      base = 0;
      for (int p = 0; p < D; p++) begin
         shEnd     = base + W * CD;
         showStart = shEnd + BC + LC;
         showLen   = BT << p;
         if (k >= base && k < shEnd) eClk = ((k - base) % CD) >= (CD / 2);
         if (k >= shEnd + BC && k < showStart) eLat = 1'b1;
         if (k >= showStart && k < showStart + showLen) eOe = !(((k - showStart) % BT) < br);
         base = showStart + showLen;
      end
   endfunction

   task automatic fillMem();
      for (int i = 0; i < (1 << (AB + 1)); i++) mem[i] = (6*D)'($urandom);
   endtask

   // Runs one row from an IDLE negedge and ends on the negedge of the done cycle
   task automatic applyStimulus(input logic [RB-1:0] r, input logic b, input logic [BRB-1:0] br, input bit hold);
      int rises, latHigh, clkErr, latErr, oeErr, idleErr, doneErr, abcdeErr, panelErr;
      int plane, x, idx, expLow;
      int oeLow [D];
      bit eClk, eLat, eOe, eEnd;
      logic prevClk;
      logic [6*D-1:0] word;
      logic [5:0] expCol;
      logic [RB-1:0] expAbcde;
      rises = 0; latHigh = 0; clkErr = 0; latErr = 0; oeErr = 0;
      idleErr = 0; doneErr = 0; abcdeErr = 0; panelErr = 0;
      for (int p = 0; p < D; p++) oeLow[p] = 0;
      checkOutput("idle_before_start", 32'(is_idle), 32'd1);
      row = r;
      bank = b;
      brightness = br;
      start = 1'b1;
      prevClk = 1'b0;
      @(posedge clock);
      for (int k = 0; k <= ROW_TIME; k++) begin
         @(negedge clock);
         if (k == 0 && !hold) start = 1'b0;
         model(k, int'(br), eClk, eLat, eOe);
         eEnd = (k == ROW_TIME);
         expAbcde = (k >= W * CD + BC) ? r : lastRow;
         if (hub_clk !== eClk) clkErr++;
         if (hub_lat !== eLat) latErr++;
         if (hub_oe !== eOe) oeErr++;
         if (is_idle !== eEnd) idleErr++;
         if (done !== eEnd) doneErr++;
         if (hub_abcde !== expAbcde) abcdeErr++;
         if (hub_lat === 1'b1) latHigh++;
         if (hub_oe === 1'b0) begin
            idx = (rises - 1) / W;
            if (rises == 0 || idx >= D) panelErr++;
            else oeLow[idx]++;
            if (hub_lat !== 1'b0 || hub_clk !== prevClk) panelErr++;
         end
         if (hub_clk === 1'b1 && prevClk === 1'b0) begin
            plane = rises / W;
            x = rises % W;
            if (rises < D * W) begin
               word = mem[{b, AB'(x)}];
               for (int c = 0; c < 6; c++) expCol[c] = word[c * D + plane];
               checkOutput($sformatf("addr_p%0d_x%0d", plane, x), 32'(read_address), 32'({b, AB'(x)}));
               checkOutput($sformatf("colour_p%0d_x%0d", plane, x), 32'(colourNow()), 32'(expCol));
            end
            rises++;
         end
         prevClk = hub_clk;
      end
      checkOutput("hub_clk_rises", 32'(rises), 32'(D * W));
      checkOutput("hub_lat_cycles", 32'(latHigh), 32'(D * LC));
      for (int p = 0; p < D; p++) begin
         expLow = ((int'(br) < BT) ? int'(br) : BT) << p;
         checkOutput($sformatf("oe_low_plane%0d", p), 32'(oeLow[p]), 32'(expLow));
      end
      checkOutput("hub_clk_timeline", 32'(clkErr), 32'd0);
      checkOutput("hub_lat_timeline", 32'(latErr), 32'd0);
      checkOutput("hub_oe_timeline", 32'(oeErr), 32'd0);
      checkOutput("is_idle_timeline", 32'(idleErr), 32'd0);
      checkOutput("done_timing", 32'(doneErr), 32'd0);
      checkOutput("hub_abcde_timeline", 32'(abcdeErr), 32'd0);
      checkOutput("panel_rules", 32'(panelErr), 32'd0);
      lastRow = r;
   endtask

   initial begin
      logic [18:0] resetExp;
      logic [6*D-1:0] word;
      logic [1:0] r1Pattern [W];
      checks = 0;
      errors = 0;
      lastRow = '0;
      resetExp = {1'b1, 17'b0, 1'b1};
      r1Pattern[0] = 2'b01;
      r1Pattern[1] = 2'b10;
      r1Pattern[2] = 2'b11;
      r1Pattern[3] = 2'b00;
      reset = 1'b1;
      start = 1'b0;
      row = '0;
      bank = 1'b0;
      brightness = '0;
      fillMem();
      repeat (2) @(negedge clock);
      checkOutput("reset_outputs", 32'(outputsNow()), 32'(resetExp));
      reset = 1'b0;

      // Reset in the middle of SHIFT
      row = 5'h0A;
      brightness = 3'd4;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1 checkOutput("reset_mid_shift", 32'(outputsNow()), 32'(resetExp));
      @(negedge clock);
      reset = 1'b0;
      lastRow = '0;
      applyStimulus(5'h0A, 1'b0, 3'd4, 1'b0);

      // Directed r1 pattern on bank 1, full brightness
      fillMem();
      for (int i = 0; i < W; i++) begin
         word = mem[{1'b1, AB'(i)}];
         word[D-1:0] = r1Pattern[i];
         mem[{1'b1, AB'(i)}] = word;
      end
      applyStimulus(5'h03, 1'b1, 3'd4, 1'b0);

      applyStimulus(5'h07, 1'b0, 3'd1, 1'b0);
      applyStimulus(5'h07, 1'b1, 3'd0, 1'b0);
      applyStimulus(5'h13, 1'b0, 3'd2, 1'b0);

      // start held through a row, then a back-to-back row
      applyStimulus(5'h1C, 1'b1, 3'd3, 1'b1);
      applyStimulus(5'h05, 1'b0, 3'd7, 1'b0);

      for (int i = 0; i < 6; i++) begin
         fillMem();
         applyStimulus(RB'($urandom), 1'($urandom), BRB'($urandom),
                       (i < 5) ? 1'($urandom) : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
